// File: rtl/timing_spi_slave_resp_if.sv
// Pin-side and local-side signal bundle for the timing board SPI responder.
// The slave modport is the responder's view; the master modport is the view of whatever drives the pins and the local bus.
interface timing_spi_slave_resp_if #(
  parameter int FRAME_BITS = 16
);
  logic                  spi_clk;
  logic                  spi_csn;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  rx_valid;
  logic [FRAME_BITS-1:0] rx_data;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic                  frame_err;
  logic [15:0]           rx_frame_cnt;

  modport slave (
    input  spi_clk, spi_csn, spi_mosi, tx_data, tx_load,
    output spi_miso, rx_valid, rx_data, tx_ready, frame_err, rx_frame_cnt
  );

  modport master (
    output spi_clk, spi_csn, spi_mosi, tx_data, tx_load,
    input  spi_miso, rx_valid, rx_data, tx_ready, frame_err, rx_frame_cnt
  );
endinterface

// File: rtl/timing_spi_slave_resp.sv
// Mode-0 SPI responder, oversampled in clk_h: receives MOSI words, returns a preloaded word on MISO.
// state | meaning
// IDLE  | csn high, or low without a seen falling edge; MISO held at 0
// SHIFT | frame in progress: sample MOSI on clk rise, advance MISO on clk fall
// DONE  | full word delivered; extra clk rises flag overrun until csn rises
module timing_spi_slave_resp #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_h,
  input  logic rst,
  timing_spi_slave_resp_if.slave bus_if
);
  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, csn_sync_q, mosi_sync_q;
  logic                  clk_hist_q, csn_hist_q;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] tx_hold_q, tx_hold_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  done_pend_q, done_pend_d;

  logic clk_s, csn_s, mosi_s;
  logic clk_rise, clk_fall, csn_rise, csn_fall, last_bit;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_hist_q;
  assign clk_fall = ~clk_s & clk_hist_q;
  assign csn_rise = csn_s & ~csn_hist_q;
  assign csn_fall = ~csn_s & csn_hist_q;
  assign last_bit = (bit_cnt_q == CW'(FRAME_BITS - 1));

  // Synchronisers reset low so a csn already low after reset never looks like a falling edge.
  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      clk_hist_q  <= 1'b0;
      csn_hist_q  <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      tx_ready_q  <= 1'b1;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus_if.spi_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus_if.spi_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_if.spi_mosi};
      clk_hist_q  <= clk_s;
      csn_hist_q  <= csn_s;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tx_ready_q  <= tx_ready_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      done_pend_q <= done_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csn_fall) state_d = SHIFT;
      SHIFT: begin
        if (csn_rise)                  state_d = IDLE;
        else if (clk_rise && last_bit) state_d = DONE;
      end
      DONE:    if (csn_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    tx_ready_d  = tx_ready_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    done_pend_d = 1'b0;

    if (bus_if.tx_load && tx_ready_q) begin
      tx_hold_d  = bus_if.tx_data;
      tx_ready_d = 1'b0;
    end

    // The word is published one cycle after its last bit is shifted in.
    if (done_pend_q) begin
      rx_data_d   = rx_shift_q;
      rx_valid_d  = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (csn_fall) begin
          bit_cnt_d  = '0;
          tx_shift_d = tx_ready_q ? '0 : tx_hold_q;
          miso_d     = tx_ready_q ? 1'b0 : tx_hold_q[FRAME_BITS-1];
          tx_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (clk_rise) begin
          rx_shift_d  = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
          bit_cnt_d   = bit_cnt_q + 1'b1;
          done_pend_d = last_bit;
        end else if (clk_fall) begin
          tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
          miso_d     = tx_shift_q[FRAME_BITS-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (!csn_rise && clk_rise) frame_err_d = 1'b1;
      end
      default: miso_d = 1'b0;
    endcase
  end

  assign bus_if.spi_miso     = miso_q;
  assign bus_if.rx_valid     = rx_valid_q;
  assign bus_if.rx_data      = rx_data_q;
  assign bus_if.tx_ready     = tx_ready_q;
  assign bus_if.frame_err    = frame_err_q;
  assign bus_if.rx_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_timing_spi_slave_resp.sv
// Directed bench for timing_spi_slave_resp: a pin-level SPI master drives frames while a
// scoreboard monitor checks every rx_valid / frame_err strobe against queued expectations.
module tb_timing_spi_slave_resp;
  logic clk_h = 1'b0;
  logic rst   = 1'b1;

  timing_spi_slave_resp_if #(.FRAME_BITS(16)) bus ();

  timing_spi_slave_resp #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk_h  (clk_h),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    logic [15:0] d;
    logic [15:0] c;
  } rx_exp_t;

  rx_exp_t     exp_rx[$];
  logic [15:0] exp_err[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_h) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rx_valid: got data 0x%0h, expected no strobe", bus.rx_data);
        end else begin
          rx_exp_t e;
          e = exp_rx.pop_front();
          chk("rx_data", {16'h0, bus.rx_data}, {16'h0, e.d});
          chk("rx_frame_cnt", {16'h0, bus.rx_frame_cnt}, {16'h0, e.c});
        end
      end
      if (bus.frame_err) begin
        if (exp_err.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame_err: got strobe, expected none");
        end else begin
          logic [15:0] c;
          c = exp_err.pop_front();
          chk("err_frame_cnt", {16'h0, bus.rx_frame_cnt}, {16'h0, c});
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_h);
    rst = 1'b1;
    repeat (2) @(negedge clk_h);
    rst = 1'b0;
    repeat (5) @(negedge clk_h);
  endtask

  task automatic load_tx(input logic [15:0] w);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge clk_h);
    bus.tx_load = 1'b0;
  endtask

  // rst_at >= 0 pulses rst just before that bit's rising edge while csn stays low.
  task automatic send_frame(input logic [15:0] word, input int nbits, input int rst_at,
                            output logic [15:0] rd, output logic rdy);
    rd = '0;
    bus.spi_csn  = 1'b0;
    bus.spi_mosi = word[15];
    repeat (3) @(negedge clk_h);
    rdy = bus.tx_ready;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk_h);
        rst = 1'b0;
        @(negedge clk_h);
      end
      if (i < 16) rd[15-i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      repeat (3) @(negedge clk_h);
      bus.spi_clk  = 1'b0;
      bus.spi_mosi = (i < 15) ? word[14-i] : 1'b0;
      repeat (3) @(negedge clk_h);
    end
    bus.spi_csn = 1'b1;
    repeat (3) @(negedge clk_h);
  endtask

  initial begin
    logic [15:0] rd;
    logic        rdy;
    bus.spi_clk  = 1'b0;
    bus.spi_csn  = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = '0;
    bus.tx_load  = 1'b0;
    repeat (3) @(negedge clk_h);
    rst = 1'b0;
    repeat (5) @(negedge clk_h);

    chk("reset_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("reset_rx_data", {16'h0, bus.rx_data}, 32'h0);
    chk("reset_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
    chk("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
    chk("reset_frame_cnt", {16'h0, bus.rx_frame_cnt}, 32'h0);
    chk("reset_miso", {31'h0, bus.spi_miso}, 32'h0);

    // 1: plain frame
    exp_rx.push_back('{d: 16'h5678, c: 16'd1});
    send_frame(16'h5678, 16, -1, rd, rdy);
    chk("t1_miso_unloaded", {16'h0, rd}, 32'h0);

    // 2: preloaded response, then an empty holding register
    do_reset();
    load_tx(16'hA5C3);
    chk("t2_tx_ready_after_load", {31'h0, bus.tx_ready}, 32'h0);
    exp_rx.push_back('{d: 16'h0001, c: 16'd1});
    send_frame(16'h0001, 16, -1, rd, rdy);
    chk("t2_miso_word", {16'h0, rd}, 32'hA5C3);
    chk("t2_tx_ready_at_start", {31'h0, rdy}, 32'h1);
    exp_rx.push_back('{d: 16'h0002, c: 16'd2});
    send_frame(16'h0002, 16, -1, rd, rdy);
    chk("t2_miso_empty", {16'h0, rd}, 32'h0);

    // 3: short frame then good frame
    do_reset();
    exp_err.push_back(16'd0);
    send_frame(16'hFFFF, 9, -1, rd, rdy);
    exp_rx.push_back('{d: 16'h1234, c: 16'd1});
    send_frame(16'h1234, 16, -1, rd, rdy);

    // 4: overrun with a 17th clock
    do_reset();
    exp_rx.push_back('{d: 16'hBEEF, c: 16'd1});
    exp_err.push_back(16'd1);
    send_frame(16'hBEEF, 17, -1, rd, rdy);

    // 5: reset mid-frame, csn held low; aborted frame must produce nothing
    do_reset();
    send_frame(16'hFFFF, 16, 8, rd, rdy);
    chk("t5_cnt_after_abort", {16'h0, bus.rx_frame_cnt}, 32'h0);
    exp_rx.push_back('{d: 16'h0F0F, c: 16'd1});
    send_frame(16'h0F0F, 16, -1, rd, rdy);

    // 6: second load ignored while first is pending, back-to-back frames
    do_reset();
    load_tx(16'h2222);
    chk("t6_tx_ready_first", {31'h0, bus.tx_ready}, 32'h0);
    load_tx(16'h1111);
    chk("t6_tx_ready_second", {31'h0, bus.tx_ready}, 32'h0);
    exp_rx.push_back('{d: 16'hAAAA, c: 16'd1});
    send_frame(16'hAAAA, 16, -1, rd, rdy);
    chk("t6_miso_first", {16'h0, rd}, 32'h2222);
    exp_rx.push_back('{d: 16'h5555, c: 16'd2});
    send_frame(16'h5555, 16, -1, rd, rdy);
    chk("t6_miso_second", {16'h0, rd}, 32'h0);
    chk("t6_final_cnt", {16'h0, bus.rx_frame_cnt}, 32'h2);

    repeat (10) @(negedge clk_h);
    chk("pending_rx_expectations", exp_rx.size(), 32'h0);
    chk("pending_err_expectations", exp_err.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
